// File: rtl/abuf2ddr_pkg.sv
// Shared constants for the accumulation-buffer to DDR write-back path.
// Package GLOBAL_PARAM: beat/slice widths, trans-type encodings, FSM state type, bw().
package GLOBAL_PARAM;

  localparam int DATA_W  = 8;
  localparam int BATCH   = 4;
  localparam int TAIL_W  = 16;
  localparam int DDR_W   = BATCH * DATA_W;
  localparam int TD_RATE = TAIL_W / DATA_W;

  localparam logic [1:0] TRANS_DATA = 2'b00;
  localparam logic [1:0] TRANS_TAIL = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } abuf_state_e;

  function automatic int bw(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

endpackage

// File: rtl/abuf2ddr_fifo.sv
// Small output FIFO with valid/ready on both sides and an occupancy count.
// Depth and width are parameters; storage is a register array, head is registered.
module abuf2ddr_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_wr_ready = (r_count != CNT_W'(DEPTH));
  assign o_rd_valid = (r_count != '0);
  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign w_wr       = i_wr_valid && o_wr_ready;
  assign w_rd       = o_rd_valid && i_rd_ready;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_wr && !w_rd)      r_count <= r_count + CNT_W'(1);
      else if (!w_wr && w_rd) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/abuf2ddr.sv
// Drains one PE's accumulation buffer to a DDR write-back stream (data or tail mode).
// Tail mode is compiled in only when ABUF2DDR_TAIL_EN is defined.
//
// state    | meaning
// IDLE     | conf_ready high, waiting for a configuration
// READ     | issuing buffer reads 0..num-1 as output credit allows
// DRAIN    | all reads issued, emptying pipeline/FIFO until the last beat
module abuf2ddr
  import GLOBAL_PARAM::*;
#(
  parameter int BUF_DEPTH = 256,
  parameter int PE_NUM    = 32,
  parameter int ADDR_W    = bw(BUF_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          conf_valid,
  output logic                          conf_ready,
  input  logic [1:0]                    conf_trans_type,
  input  logic [15:0]                   conf_trans_num,
  input  logic [bw(PE_NUM)-1:0]         conf_pe_sel,
  output logic [ADDR_W-1:0]             abuf_rd_addr,
  output logic                          abuf_rd_en,
  input  logic [PE_NUM*BATCH*DATA_W-1:0] abuf_rd_data,
`ifdef ABUF2DDR_TAIL_EN
  input  logic [PE_NUM*BATCH*TAIL_W-1:0] abuf_rd_tail,
`endif
  output logic [DDR_W-1:0]              ddr_data,
  output logic                          ddr_valid,
  input  logic                          ddr_ready,
  output logic                          ddr_last
);

  localparam int PS_W     = bw(PE_NUM);
  localparam int DSLICE_W = BATCH * DATA_W;
  localparam int TSLICE_W = BATCH * TAIL_W;
`ifdef ABUF2DDR_TAIL_EN
  localparam int FIFO_DEPTH = (TD_RATE > 2) ? TD_RATE : 2;
`else
  localparam int FIFO_DEPTH = 2;
`endif
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CW     = bw(FIFO_DEPTH + 2 * TD_RATE + 2) + 1;

  abuf_state_e r_state, w_state_nxt;

  logic [15:0]         r_num;
  logic [PS_W-1:0]     r_pe_sel;
  logic                r_tail_mode;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_rd_cnt;
  logic                r_rd_pend;
  logic                r_rd_pend_last;
  logic [TSLICE_W-1:0] r_ser_data;
  logic [CW-1:0]       r_ser_cnt;
  logic                r_ser_last;

  logic                w_accept;
  logic                w_start;
  logic                w_tail_req;
  logic                w_type_ok;
  logic                w_rd_issue;
  logic                w_last_rd;
  logic                w_pop;
  logic [CW-1:0]       w_beats;
  logic [CW-1:0]       w_occ_after;
  logic [CW-1:0]       w_inflight;
  logic                w_credit_ok;
  logic [DSLICE_W-1:0] w_arr_data;
  logic [TSLICE_W-1:0] w_arr_tail;
  logic                w_push;
  logic [DDR_W-1:0]    w_push_data;
  logic                w_push_last;
  logic                w_fifo_wr_ready;
  logic                w_fifo_valid;
  logic [DDR_W:0]      w_fifo_head;
  logic [FCNT_W-1:0]   w_fifo_count;

`ifdef ABUF2DDR_TAIL_EN
  assign w_tail_req = (conf_trans_type == TRANS_TAIL);
`else
  assign w_tail_req = 1'b0;
`endif
  assign w_type_ok  = (conf_trans_type == TRANS_DATA) || w_tail_req;

  assign conf_ready   = (r_state == ST_IDLE);
  assign abuf_rd_en   = w_rd_issue;
  assign abuf_rd_addr = r_addr;

  // Credit: FIFO occupancy after this cycle's pop, plus beats still in flight,
  // plus the beats this read would add, must fit in the FIFO.
  assign w_pop       = w_fifo_valid && ddr_ready;
  assign w_beats     = r_tail_mode ? CW'(TD_RATE) : CW'(1);
  assign w_occ_after = CW'(w_fifo_count) - CW'(w_pop);
  assign w_inflight  = (r_rd_pend ? w_beats : '0) + r_ser_cnt;
  assign w_credit_ok = (w_occ_after + w_inflight + w_beats) <= CW'(FIFO_DEPTH);
  assign w_rd_issue  = (r_state == ST_READ) && w_credit_ok;
  assign w_last_rd   = (r_rd_cnt == r_num - 16'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (conf_valid) begin
          w_accept = 1'b1;
          if (w_type_ok && (conf_trans_num != 16'd0)) begin
            w_start     = 1'b1;
            w_state_nxt = ST_READ;
          end
        end
      end
      ST_READ:  if (w_rd_issue && w_last_rd) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_pop && w_fifo_head[DDR_W]) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_num       <= '0;
      r_pe_sel    <= '0;
      r_tail_mode <= 1'b0;
    end else if (w_accept) begin
      r_num       <= conf_trans_num;
      r_pe_sel    <= conf_pe_sel;
      r_tail_mode <= w_tail_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr         <= '0;
      r_rd_cnt       <= '0;
      r_rd_pend      <= 1'b0;
      r_rd_pend_last <= 1'b0;
    end else begin
      r_rd_pend      <= w_rd_issue;
      r_rd_pend_last <= w_rd_issue && w_last_rd;
      if (w_start) begin
        r_addr   <= '0;
        r_rd_cnt <= '0;
      end else if (w_rd_issue) begin
        r_addr   <= (r_addr == ADDR_W'(BUF_DEPTH - 1)) ? '0 : r_addr + ADDR_W'(1);
        r_rd_cnt <= r_rd_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    w_arr_data = '0;
    w_arr_tail = '0;
    for (int p = 0; p < PE_NUM; p++) begin
      if (r_pe_sel == PS_W'(p)) begin
        w_arr_data = abuf_rd_data[p*DSLICE_W +: DSLICE_W];
`ifdef ABUF2DDR_TAIL_EN
        w_arr_tail = abuf_rd_tail[p*TSLICE_W +: TSLICE_W];
`endif
      end
    end
  end

  // Fresh read data goes straight into the FIFO so the first beat costs no
  // extra cycle; remaining tail slices are serialised from r_ser_data.
  always_comb begin
    w_push      = 1'b0;
    w_push_data = '0;
    w_push_last = 1'b0;
    if (r_rd_pend) begin
      w_push = 1'b1;
      if (r_tail_mode) begin
        w_push_data = w_arr_tail[DDR_W-1:0];
        w_push_last = r_rd_pend_last && (TD_RATE == 1);
      end else begin
        w_push_data = w_arr_data;
        w_push_last = r_rd_pend_last;
      end
    end else if (r_ser_cnt != '0) begin
      w_push      = 1'b1;
      w_push_data = r_ser_data[DDR_W-1:0];
      w_push_last = r_ser_last && (r_ser_cnt == CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ser_data <= '0;
      r_ser_cnt  <= '0;
      r_ser_last <= 1'b0;
    end else if (r_rd_pend && r_tail_mode) begin
      r_ser_data <= w_arr_tail >> DDR_W;
      r_ser_cnt  <= CW'(TD_RATE - 1);
      r_ser_last <= r_rd_pend_last;
    end else if (r_ser_cnt != '0) begin
      r_ser_data <= r_ser_data >> DDR_W;
      r_ser_cnt  <= r_ser_cnt - CW'(1);
    end
  end

  abuf2ddr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DDR_W + 1),
    .CNT_W (FCNT_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_wr_valid (w_push && w_fifo_wr_ready),
    .o_wr_ready (w_fifo_wr_ready),
    .i_wr_data  ({w_push_last, w_push_data}),
    .o_rd_valid (w_fifo_valid),
    .i_rd_ready (ddr_ready),
    .o_rd_data  (w_fifo_head),
    .o_count    (w_fifo_count)
  );

  assign ddr_valid = w_fifo_valid;
  assign ddr_data  = w_fifo_head[DDR_W-1:0];
  assign ddr_last  = w_fifo_head[DDR_W];

endmodule
